// File: rtl/scarv_cop_palu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : scarv_cop_palu_seq_if
// Brief    : Issue-side and writeback-side handshake bundle of the packed ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface scarv_cop_palu_seq_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [2:0]      in_pw;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [5:0]      in_shamt;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic            out_err;

    modport master (
        output in_valid, in_op, in_pw, in_rs1, in_rs2, in_shamt, flush, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_op, in_pw, in_rs1, in_rs2, in_shamt, flush, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface
`default_nettype wire

// File: rtl/scarv_cop_palu_seq.sv
`default_nettype none
// ============================================================================
// Module   : scarv_cop_palu_seq
// Brief    : Handshaked packed ALU (add/sub/shift/rotate, iterative multiply).
//            Optional signed saturating ADDS/SUBS under SCARV_COP_PALU_SEQ_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module scarv_cop_palu_seq #(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 1
) (
    input wire                  g_clk,
    input wire                  g_resetn,
    scarv_cop_palu_seq_if.slave bus
);

    localparam int NPW = $clog2(XLEN);
    localparam int CW  = 7;

    localparam logic [2:0] c_OP_ADD  = 3'd0;
    localparam logic [2:0] c_OP_SUB  = 3'd1;
    localparam logic [2:0] c_OP_SLL  = 3'd2;
    localparam logic [2:0] c_OP_SRL  = 3'd3;
    localparam logic [2:0] c_OP_ROTL = 3'd4;
    localparam logic [2:0] c_OP_MUL  = 3'd5;
    localparam logic [2:0] c_OP_ADDS = 3'd6;
    localparam logic [2:0] c_OP_SUBS = 3'd7;

    localparam logic [2:0] c_PW_LIM = 3'(NPW);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_data;
    logic            r_err;
    logic [XLEN-1:0] r_mul_a;
    logic [XLEN-1:0] r_mul_b;
    logic [XLEN-1:0] r_mul_acc;
    logic [CW-1:0]   r_mul_cnt;
    logic [2:0]      r_mul_pw;

    // Per-lane-width results, indexed directly by the 3-bit pw field.
    logic [XLEN-1:0] w_alu_pw     [0:7];
    logic [XLEN-1:0] w_acc_nxt_pw [0:7];
    logic [XLEN-1:0] w_a_nxt_pw   [0:7];
    logic [XLEN-1:0] w_b_nxt_pw   [0:7];
    logic [CW-1:0]   w_last_pw    [0:7];

    for (genvar p = 0; p < 8; p++) begin : g_pw
        if (p < NPW) begin : g_legal
            localparam int LW = XLEN >> p;
            localparam int NL = 1 << p;
            localparam int MB = (MUL_BPC < LW) ? MUL_BPC : LW;
            localparam int SW = $clog2(LW);
            localparam logic [LW-1:0] C_BMASK = LW'((64'd1 << MB) - 64'd1);

            logic [XLEN-1:0] w_res;
            logic [XLEN-1:0] w_acc;
            logic [XLEN-1:0] w_a;
            logic [XLEN-1:0] w_b;

            for (genvar l = 0; l < NL; l++) begin : g_lane
                logic [LW-1:0] w_lhs;
                logic [LW-1:0] w_rhs;
                logic [LW-1:0] w_sum;
                logic [LW-1:0] w_dif;
                logic [LW-1:0] w_rot;
                logic [LW-1:0] w_rot_unused_lo;
                logic [LW-1:0] w_out;
                logic [LW-1:0] w_ma;
                logic [LW-1:0] w_mb;
                logic [LW-1:0] w_pp;
                logic [SW-1:0] w_amt;

                assign w_lhs = bus.in_rs1[l*LW +: LW];
                assign w_rhs = bus.in_rs2[l*LW +: LW];
                assign w_amt = bus.in_shamt[SW-1:0];
                assign w_sum = w_lhs + w_rhs;
                assign w_dif = w_lhs - w_rhs;
                assign {w_rot, w_rot_unused_lo} = {w_lhs, w_lhs} << w_amt;

`ifdef SCARV_COP_PALU_SEQ_SAT_EN
                localparam logic [LW-1:0] C_SMAX = {1'b0, {(LW-1){1'b1}}};
                localparam logic [LW-1:0] C_SMIN = {1'b1, {(LW-1){1'b0}}};
                logic          w_ovf_add;
                logic          w_ovf_sub;
                logic [LW-1:0] w_clamp;
                logic [LW-1:0] w_sat_add;
                logic [LW-1:0] w_sat_sub;

                // Overflow always saturates toward the sign of the lhs operand.
                assign w_clamp   = w_lhs[LW-1] ? C_SMIN : C_SMAX;
                assign w_ovf_add = (w_lhs[LW-1] == w_rhs[LW-1]) && (w_sum[LW-1] != w_lhs[LW-1]);
                assign w_ovf_sub = (w_lhs[LW-1] != w_rhs[LW-1]) && (w_dif[LW-1] != w_lhs[LW-1]);
                assign w_sat_add = w_ovf_add ? w_clamp : w_sum;
                assign w_sat_sub = w_ovf_sub ? w_clamp : w_dif;
`endif

                always_comb begin
                    w_out = '0;
                    case (bus.in_op)
                        c_OP_ADD:  w_out = w_sum;
                        c_OP_SUB:  w_out = w_dif;
                        c_OP_SLL:  w_out = w_lhs << w_amt;
                        c_OP_SRL:  w_out = w_lhs >> w_amt;
                        c_OP_ROTL: w_out = w_rot;
`ifdef SCARV_COP_PALU_SEQ_SAT_EN
                        c_OP_ADDS: w_out = w_sat_add;
                        c_OP_SUBS: w_out = w_sat_sub;
`endif
                        default:   w_out = '0;
                    endcase
                end

                assign w_res[l*LW +: LW] = w_out;

                // Multiplicand pre-shifted and multiplier consumed from the bottom,
                // equivalent to indexing both by cnt*MUL_BPC.
                assign w_ma = r_mul_a[l*LW +: LW];
                assign w_mb = r_mul_b[l*LW +: LW];
                assign w_pp = w_ma * (w_mb & C_BMASK);

                assign w_acc[l*LW +: LW] = r_mul_acc[l*LW +: LW] + w_pp;
                assign w_a[l*LW +: LW]   = w_ma << MB;
                assign w_b[l*LW +: LW]   = w_mb >> MB;
            end

            assign w_alu_pw[p]     = w_res;
            assign w_acc_nxt_pw[p] = w_acc;
            assign w_a_nxt_pw[p]   = w_a;
            assign w_b_nxt_pw[p]   = w_b;
            assign w_last_pw[p]    = CW'((LW + MUL_BPC - 1) / MUL_BPC - 1);
        end else begin : g_illegal
            assign w_alu_pw[p]     = '0;
            assign w_acc_nxt_pw[p] = '0;
            assign w_a_nxt_pw[p]   = '0;
            assign w_b_nxt_pw[p]   = '0;
            assign w_last_pw[p]    = '0;
        end
    end

    logic            w_pw_ok;
    logic            w_op_ok;
    logic            w_err;
    logic            w_is_mul;
    logic            w_accept;
    logic            w_mul_done;
    logic [XLEN-1:0] w_alu_data;
    logic            w_unused_shamt;

    assign w_pw_ok = (bus.in_pw < c_PW_LIM);
`ifdef SCARV_COP_PALU_SEQ_SAT_EN
    assign w_op_ok = 1'b1;
`else
    assign w_op_ok = (bus.in_op != c_OP_ADDS) && (bus.in_op != c_OP_SUBS);
`endif
    assign w_err          = !w_pw_ok || !w_op_ok;
    assign w_is_mul       = (bus.in_op == c_OP_MUL) && w_pw_ok;
    assign w_alu_data     = w_err ? '0 : w_alu_pw[bus.in_pw];
    assign w_mul_done     = (r_mul_cnt == w_last_pw[r_mul_pw]);
    assign w_unused_shamt = ^bus.in_shamt;

    // flush masks acceptance outright, even when a HOLD result is being consumed.
    assign bus.in_ready  = !bus.flush &&
                           ((r_state == c_ST_IDLE) || ((r_state == c_ST_HOLD) && bus.out_ready));
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (r_state == c_ST_HOLD);
    assign bus.out_data  = r_data;
    assign bus.out_err   = r_err;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state   <= c_ST_IDLE;
            r_data    <= '0;
            r_err     <= 1'b0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_mul_acc <= '0;
            r_mul_cnt <= '0;
            r_mul_pw  <= '0;
        end else if (bus.flush) begin
            r_state   <= c_ST_IDLE;
            r_mul_acc <= '0;
            r_mul_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_BUSY: begin
                    r_mul_acc <= w_acc_nxt_pw[r_mul_pw];
                    r_mul_a   <= w_a_nxt_pw[r_mul_pw];
                    r_mul_b   <= w_b_nxt_pw[r_mul_pw];
                    r_mul_cnt <= r_mul_cnt + 1'b1;
                    if (w_mul_done) begin
                        r_data  <= w_acc_nxt_pw[r_mul_pw];
                        r_err   <= 1'b0;
                        r_state <= c_ST_HOLD;
                    end
                end
                c_ST_IDLE, c_ST_HOLD: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_mul_a   <= bus.in_rs1;
                            r_mul_b   <= bus.in_rs2;
                            r_mul_acc <= '0;
                            r_mul_cnt <= '0;
                            r_mul_pw  <= bus.in_pw;
                            r_state   <= c_ST_BUSY;
                        end else begin
                            r_data  <= w_alu_data;
                            r_err   <= w_err;
                            r_state <= c_ST_HOLD;
                        end
                    end else if ((r_state == c_ST_HOLD) && bus.out_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scarv_cop_palu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_scarv_cop_palu_seq
// Brief    : Directed self-checking bench for scarv_cop_palu_seq (XLEN=32, MUL_BPC=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_scarv_cop_palu_seq;

    logic g_clk;
    logic g_resetn;
    int   n_vec;
    int   n_err;
    int   n_cyc;
    int   n_seen;

    scarv_cop_palu_seq_if #(.XLEN(32)) bus ();

    scarv_cop_palu_seq #(
        .XLEN    (32),
        .MUL_BPC (1)
    ) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (bus)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] pw,
                         input logic [31:0] a, input logic [31:0] b, input logic [5:0] sh);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_pw    = pw;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        bus.in_shamt = sh;
        #1;
        check("in_ready_at_issue", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget, output int cycles);
        cycles = 1;
        while (!bus.out_valid && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        g_resetn      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_pw     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_shamt  = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_out_err",   64'(bus.out_err),   64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        g_resetn = 1'b1;
        tick();

        issue(3'd0, 3'd2, 32'h01FF7F80, 32'h01010101, 6'd0);
        check("add_valid", 64'(bus.out_valid), 64'd1);
        check("add_data",  64'(bus.out_data),  64'h02008081);
        check("add_err",   64'(bus.out_err),   64'd0);
        tick();
        check("idle_after_consume", 64'(bus.out_valid), 64'd0);

        issue(3'd1, 3'd1, 32'h00000005, 32'h00010006, 6'd0);
        check("sub_data", 64'(bus.out_data), 64'hFFFFFFFF);
        tick();
        issue(3'd4, 3'd2, 32'h80010203, 32'h0, 6'd9);
        check("rotl_data", 64'(bus.out_data), 64'h01020406);
        tick();
        issue(3'd2, 3'd0, 32'h80000001, 32'h0, 6'd33);
        check("sll_data", 64'(bus.out_data), 64'h00000002);
        tick();
        issue(3'd3, 3'd3, 32'hF0F08421, 32'h0, 6'd5);
        check("srl_data", 64'(bus.out_data), 64'h70704210);
        tick();

        issue(3'd5, 3'd1, 32'h00030100, 32'h00050100, 6'd0);
        for (int i = 1; i <= 16; i++) begin
            check("mul16_busy_valid", 64'(bus.out_valid), 64'd0);
            check("mul16_busy_ready", 64'(bus.in_ready),  64'd0);
            tick();
        end
        check("mul16_valid", 64'(bus.out_valid), 64'd1);
        check("mul16_data",  64'(bus.out_data),  64'h000F0000);
        check("mul16_err",   64'(bus.out_err),   64'd0);
        tick();

        issue(3'd5, 3'd4, 32'hFFFFFFFF, 32'hAAAAAAAA, 6'd0);
        wait_out(100, n_cyc);
        check("mul2_latency", 64'(n_cyc), 64'd3);
        check("mul2_data", 64'(bus.out_data), 64'hAAAAAAAA);
        tick();
        issue(3'd5, 3'd0, 32'h12345678, 32'h00000003, 6'd0);
        wait_out(100, n_cyc);
        check("mul32_latency", 64'(n_cyc), 64'd33);
        check("mul32_data", 64'(bus.out_data), 64'h369D0368);
        tick();

        // Backpressure with a competing request, then back-to-back acceptance.
        issue(3'd0, 3'd0, 32'd1, 32'd2, 6'd0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = 3'd1;
        bus.in_pw     = 3'd0;
        bus.in_rs1    = 32'd10;
        bus.in_rs2    = 32'd3;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_data",  64'(bus.out_data),  64'd3);
            check("bp_ready", 64'(bus.in_ready),  64'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_ready_release", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_next_valid", 64'(bus.out_valid), 64'd1);
        check("bp_next_data",  64'(bus.out_data),  64'd7);
        tick();
        check("bp_idle", 64'(bus.out_valid), 64'd0);

        // flush during the fifth MUL iteration, with a competing request.
        issue(3'd5, 3'd1, 32'h00030100, 32'h00050100, 6'd0);
        repeat (4) tick();
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd0;
        #1;
        check("flush_blocks_accept", 64'(bus.in_ready), 64'd0);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("flush_busy_valid", 64'(bus.out_valid), 64'd0);
        check("flush_busy_ready", 64'(bus.in_ready),  64'd1);
        n_seen = 0;
        repeat (20) begin
            if (bus.out_valid) n_seen++;
            tick();
        end
        check("flush_busy_no_result", 64'(n_seen), 64'd0);

        issue(3'd0, 3'd0, 32'd1, 32'd2, 6'd0);
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        tick();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("flush_hold_valid", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset in the middle of a multiply.
        issue(3'd5, 3'd0, 32'h12345678, 32'h00000003, 6'd0);
        repeat (3) tick();
        g_resetn = 1'b0;
        #1;
        check("arst_valid", 64'(bus.out_valid), 64'd0);
        check("arst_data",  64'(bus.out_data),  64'd0);
        check("arst_err",   64'(bus.out_err),   64'd0);
        check("arst_ready", 64'(bus.in_ready),  64'd1);
        repeat (2) tick();
        g_resetn = 1'b1;
        n_seen = 0;
        repeat (40) begin
            if (bus.out_valid) n_seen++;
            tick();
        end
        check("arst_no_result", 64'(n_seen), 64'd0);

        issue(3'd0, 3'd0, 32'd5, 32'd6, 6'd0);
        check("pre_sat_data", 64'(bus.out_data), 64'd11);
        tick();
        issue(3'd6, 3'd2, 32'h00007F80, 32'h000001FF, 6'd0);
        check("adds_valid", 64'(bus.out_valid), 64'd1);
`ifdef SCARV_COP_PALU_SEQ_SAT_EN
        check("adds_data", 64'(bus.out_data), 64'h00007F80);
        check("adds_err",  64'(bus.out_err),  64'd0);
`else
        check("adds_data", 64'(bus.out_data), 64'h0);
        check("adds_err",  64'(bus.out_err),  64'd1);
`endif
        tick();
        issue(3'd7, 3'd2, 32'h00000080, 32'h00000001, 6'd0);
`ifdef SCARV_COP_PALU_SEQ_SAT_EN
        check("subs_data", 64'(bus.out_data), 64'h00000080);
        check("subs_err",  64'(bus.out_err),  64'd0);
`else
        check("subs_data", 64'(bus.out_data), 64'h0);
        check("subs_err",  64'(bus.out_err),  64'd1);
`endif
        tick();

        issue(3'd0, 3'd0, 32'd20, 32'd22, 6'd0);
        check("pre_pw_data", 64'(bus.out_data), 64'd42);
        tick();
        issue(3'd0, 3'd5, 32'd1, 32'd1, 6'd0);
        check("pw5_valid", 64'(bus.out_valid), 64'd1);
        check("pw5_data",  64'(bus.out_data),  64'd0);
        check("pw5_err",   64'(bus.out_err),   64'd1);
        tick();
        issue(3'd5, 3'd7, 32'd3, 32'd3, 6'd0);
        check("pw7_mul_valid", 64'(bus.out_valid), 64'd1);
        check("pw7_mul_err",   64'(bus.out_err),   64'd1);
        tick();
        check("final_idle", 64'(bus.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scarv_cop_palu_seq.md
Name: scarv_cop_palu_seq

Overview:
Parametrised, handshaked packed ALU for the SCARV coprocessor, a successor to the combinational packed-arithmetic path.
- Supports XLEN-wide operands, every power-of-two lane width from 2 to XLEN, and packed shifts and rotates.
- Multiply is iterative, with a configurable number of multiplier bits consumed per cycle.
- Sits between the coprocessor decode/issue stage and CPR writeback, using valid/ready handshakes on both sides with a registered output.

Parameters:
XLEN, 32, operand and result width; power of two, 32 or 64.
MUL_BPC, 1, multiplier bits consumed per MUL iteration; power of two, 1..8.

Ports:
g_clk  in  1  clock
g_resetn  in  1  asynchronous active-low reset
in_valid  in  1  operation presented
in_ready  out  1  operation accepted when in_valid & in_ready at posedge
in_op  in  3  0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 ROTL, 5 MUL, 6 ADDS, 7 SUBS
in_pw  in  3  lane width = XLEN >> in_pw
in_rs1  in  XLEN  lhs operand
in_rs2  in  XLEN  rhs operand
in_shamt  in  6  shift/rotate amount
flush  in  1  synchronous abort
out_valid  out  1  result available
out_ready  in  1  result consumed when out_valid & out_ready
out_data  out  XLEN  result
out_err  out  1  illegal pw or op accompanying out_data

Behaviour:
- Reset: state=IDLE; out_valid=0, out_data=0, out_err=0, internal accumulator and counter cleared.
- Asynchronous reset mid-operation discards all work; no output is produced.
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: MUL iterating; in_ready=0.
  - HOLD: out_valid=1; in_ready=out_ready, so back-to-back acceptance is allowed.
- Accept in IDLE or HOLD:
  - Non-MUL ops: the result is computed combinationally and registered. Next state is HOLD, so out_valid rises the cycle after acceptance (1-cycle latency).
  - MUL: latch operands, counter=0, accumulator=0, go to BUSY.
- HOLD with out_ready and no new accept: go to IDLE, out_valid=0.
- out_data and out_err are stable while out_valid & !out_ready.
- BUSY iteration, per cycle, in every lane simultaneously:
  - acc_lane += (a_lane << (cnt*MUL_BPC)) * b_lane[cnt*MUL_BPC +: MUL_BPC], truncated to lane width.
  - cnt++.
  - After ceil(lane_w/MUL_BPC) iterations, load out_data=acc and go to HOLD.
  - MUL result is the low lane_w bits of each lane product; latency from acceptance to out_valid = ceil(lane_w/MUL_BPC)+1 cycles.
- ADD/SUB: modulo 2^lane_w per lane; no carry crosses a lane boundary.
- SLL/SRL/ROTL: amount = in_shamt mod lane_w, applied per lane; SRL is logical.
- Illegal pw (lane_w < 2, or in_pw > log2(XLEN)-1): out_data=0, out_err=1, 1-cycle latency.
- flush:
  - Forces IDLE next cycle from any state, dropping the BUSY operation and any HOLD result; out_valid=0.
  - An in_valid in the same cycle as flush is not accepted (in_ready=0 while flush=1).
  - flush has priority over out_ready.

Optional Feature:
SCARV_COP_PALU_SEQ_SAT_EN.
- Defined: ADDS/SUBS perform per-lane signed saturating add/subtract, clamping to [-2^(lane_w-1), 2^(lane_w-1)-1]; 1-cycle latency.
- Undefined: ADDS/SUBS are illegal, giving out_data=0 and out_err=1; the saturation logic is absent.

Test Plan:
- ADD pw=2 (8-bit lanes), rs1=0x01FF7F80, rs2=0x01010101 -> out_data=0x02008081, out_err=0, out_valid exactly 1 cycle after acceptance.
- SUB pw=1, rs1=0x00000005, rs2=0x00010006 -> 0xFFFFFFFF; ROTL pw=2, shamt=9, rs1=0x80010203 -> 0x01020406.
- MUL pw=1, MUL_BPC=1, rs1=0x00030100, rs2=0x00050100 -> 0x000F0000, out_valid 17 cycles after acceptance, in_ready=0 throughout BUSY.
- Backpressure: hold out_ready=0 for 3 cycles after a result -> out_data stable and in_ready=0; then out_ready=1 together with new in_valid -> new op accepted that cycle, next result 1 cycle later.
- flush during BUSY at iteration 5, and g_resetn asserted during another MUL -> no out_valid; IDLE next cycle with in_ready=1; all outputs at reset values after reset.
- With SAT_EN: ADDS pw=2, rs1=0x7F80, rs2=0x01FF -> 0x7F80, out_err=0. Without SAT_EN: same op -> 0x00000000, out_err=1. pw=5 with XLEN=32 -> out_err=1.
